// File: rtl/nios2_ocimem_arbiter_if.sv
// CPU monitor data-master port and ociram port of the debug-RAM arbiter.
// slave = arbiter side, master = CPU/RAM environment side.
interface nios2_ocimem_arbiter_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [31:0]       cpu_writedata;
    logic [3:0]        cpu_byteenable;
    logic [31:0]       cpu_readdata;
    logic              cpu_waitrequest;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [31:0]       ram_wrdata;
    logic [3:0]        ram_be;
    logic [31:0]       ram_rddata;

    modport slave (
        input  cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable, ram_rddata,
        output cpu_readdata, cpu_waitrequest, ram_addr, ram_wr, ram_wrdata, ram_be
    );

    modport master (
        output cpu_address, cpu_read, cpu_write, cpu_writedata, cpu_byteenable, ram_rddata,
        input  cpu_readdata, cpu_waitrequest, ram_addr, ram_wr, ram_wrdata, ram_be
    );
endinterface

// File: rtl/nios2_ocimem_arbiter.sv
// Shares the single ociram port between queued JTAG debug commands and the CPU
// monitor master, with round-robin arbitration and JTAG address auto-increment.
module nios2_ocimem_arbiter #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [37:0]                  jdo,
    input  logic                         take_action_ocimem_a,
    input  logic                         take_action_ocimem_b,
    input  logic                         take_no_action_ocimem_a,
    nios2_ocimem_arbiter_if.slave        bus,
    output logic [31:0]                  mon_dreg,
    output logic                         mon_ready,
    output logic                         mon_error
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 2;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {ST_IDLE, ST_RD_JTAG, ST_RD_CPU} state_t;

    state_t            state, state_next;
    cmd_t              fifo [2];
    cmd_t              new_cmd;
    logic [CNT_W-1:0]  count, count_next;
    logic [ADDR_W-1:0] jptr, jdo_addr;
    logic              last_jtag;
    logic              req, full, enq, deq, drop, wr_idx;
    logic              grant_j, grant_c, jreq, creq;
    logic              unused_jdo;

    assign jdo_addr   = jdo[26 +: ADDR_W];
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    // Strobe decode: _a > _b > no_action; a bare _a only reloads the pointer.
    always_comb begin
        req     = 1'b0;
        new_cmd = '0;
        if (take_action_ocimem_a) begin
            req     = jdo[34];
            new_cmd = '{wr: 1'b0, addr: jdo_addr, data: '0};
        end else if (take_action_ocimem_b) begin
            req     = 1'b1;
            new_cmd = '{wr: 1'b1, addr: jptr, data: jdo[34:3]};
        end else if (take_no_action_ocimem_a) begin
            req     = 1'b1;
            new_cmd = '{wr: 1'b0, addr: jptr, data: '0};
        end
    end

    assign full       = (count == CNT_W'(2));
    assign deq        = grant_j;
    assign enq        = req && (!full || deq);
    assign drop       = req && full && !deq;
    assign wr_idx     = (count == CNT_W'(2)) || ((count == CNT_W'(1)) && !deq);
    assign count_next = count + CNT_W'(enq) - CNT_W'(deq);
    assign jreq       = (count != '0);
    assign creq       = bus.cpu_read || bus.cpu_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Arbitration and RAM/CPU port drive; grants only happen in IDLE.
    always_comb begin
        state_next          = state;
        grant_j             = 1'b0;
        grant_c             = 1'b0;
        bus.ram_addr        = '0;
        bus.ram_wr          = 1'b0;
        bus.ram_wrdata      = '0;
        bus.ram_be          = '0;
        bus.cpu_readdata    = '0;
        bus.cpu_waitrequest = 1'b1;
        case (state)
            ST_IDLE: begin
                if (jreq && (!creq || !last_jtag)) begin
                    grant_j      = 1'b1;
                    bus.ram_addr = fifo[0].addr;
                    if (fifo[0].wr) begin
                        bus.ram_wr     = 1'b1;
                        bus.ram_wrdata = fifo[0].data;
                        bus.ram_be     = BE_W'(4'hF);
                    end else begin
                        state_next = ST_RD_JTAG;
                    end
                end else if (creq) begin
                    grant_c      = 1'b1;
                    bus.ram_addr = bus.cpu_address;
                    if (bus.cpu_write) begin
                        bus.ram_wr          = 1'b1;
                        bus.ram_wrdata      = bus.cpu_writedata;
                        bus.ram_be          = bus.cpu_byteenable;
                        bus.cpu_waitrequest = 1'b0;
                    end else begin
                        state_next = ST_RD_CPU;
                    end
                end
            end
            ST_RD_JTAG: state_next = ST_IDLE;
            ST_RD_CPU: begin
                state_next          = ST_IDLE;
                bus.cpu_readdata    = bus.ram_rddata;
                bus.cpu_waitrequest = 1'b0;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command FIFO, address pointer, round-robin history and host status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo[0]   <= '0;
            fifo[1]   <= '0;
            count     <= '0;
            jptr      <= '0;
            last_jtag <= 1'b0;
            mon_dreg  <= '0;
            mon_ready <= 1'b1;
            mon_error <= 1'b0;
        end else begin
            if (deq) fifo[0] <= fifo[1];
            if (enq) fifo[wr_idx] <= new_cmd;
            count <= count_next;

            if (take_action_ocimem_a) begin
                if (!jdo[34])  jptr <= jdo_addr;
                else if (enq)  jptr <= jdo_addr + ADDR_W'(1);
            end else if (enq) begin
                jptr <= jptr + ADDR_W'(1);
            end

            if (grant_j)      last_jtag <= 1'b1;
            else if (grant_c) last_jtag <= 1'b0;

            if (state == ST_RD_JTAG) mon_dreg <= bus.ram_rddata;

            if (take_action_ocimem_a) mon_error <= 1'b0;
            else if (drop)            mon_error <= 1'b1;

            // Ready looks at next state so the last read's data and ready coincide.
            if (enq)                                          mon_ready <= 1'b0;
            else if (state_next == ST_IDLE && count_next == '0) mon_ready <= 1'b1;
        end
    end
endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Scoreboard bench for nios2_ocimem_arbiter: expected RAM writes and JTAG read
// results are queued at stimulus time and checked as the DUT produces them.
module tb_nios2_ocimem_arbiter;
    localparam int K_A = 0, K_B = 1, K_NA = 2, K_NONE = 3;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        act_a, act_b, na;
    logic [31:0] mon_dreg;
    logic        mon_ready, mon_error;
    logic [31:0] mem [256];

    int          tests = 0;
    int          fails = 0;
    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];

    nios2_ocimem_arbiter_if #(.ADDR_W(8)) bus ();

    nios2_ocimem_arbiter #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (act_a),
        .take_action_ocimem_b    (act_b),
        .take_no_action_ocimem_a (na),
        .bus                     (bus),
        .mon_dreg                (mon_dreg),
        .mon_ready               (mon_ready),
        .mon_error               (mon_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {24'hC0DE00, a};
    endfunction

    // RAM model: one-cycle read latency, byte-enabled writes, reloaded during reset.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
        end else if (bus.ram_wr) begin
            for (int b = 0; b < 4; b++)
                if (bus.ram_be[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wrdata[8*b +: 8];
        end
        bus.ram_rddata <= mem[bus.ram_addr];
    end

    // Every RAM write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset_n && bus.ram_wr) begin
            tests++;
            if (exp_wr.size() == 0) begin
                fails++;
                $display("FAIL ram_write unexpected: addr=%h data=%h be=%h, none required",
                         bus.ram_addr, bus.ram_wrdata, bus.ram_be);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                if (bus.ram_addr !== e.addr || bus.ram_wrdata !== e.data || bus.ram_be !== e.be) begin
                    fails++;
                    $display("FAIL ram_write: got addr=%h data=%h be=%h, required addr=%h data=%h be=%h",
                             bus.ram_addr, bus.ram_wrdata, bus.ram_be, e.addr, e.data, e.be);
                end
            end
        end
    end

    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
        logic [37:0] v;
        v        = '0;
        v[33:26] = addr;
        v[34]    = rd;
        return v;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        logic [37:0] v;
        v       = '0;
        v[34:3] = data;
        return v;
    endfunction

    task automatic strobe_set(input int kind, input logic [37:0] v);
        jdo   = v;
        act_a = (kind == K_A);
        act_b = (kind == K_B);
        na    = (kind == K_NA);
    endtask

    task automatic cpu_idle();
        bus.cpu_read       = 1'b0;
        bus.cpu_write      = 1'b0;
        bus.cpu_address    = '0;
        bus.cpu_writedata  = '0;
        bus.cpu_byteenable = '0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        cpu_idle();
        strobe_set(K_NONE, '0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (!mon_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = mon_ready;
    endtask

    // Drops cpu_read/cpu_write right after a cycle in which the CPU transfer completed.
    task automatic cpu_release(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (!bus.cpu_waitrequest) ok = 1'b1;
            n++;
        end
        @(posedge clk); #1;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cpu_idle();
        strobe_set(K_NONE, '0);
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.ram_wr !== 1'b0) begin fails++; $display("FAIL rst_ram_wr: got %b, required 0", bus.ram_wr); end
        tests++; if (bus.ram_addr !== 8'h00) begin fails++; $display("FAIL rst_ram_addr: got %h, required 00", bus.ram_addr); end
        tests++; if (bus.ram_wrdata !== 32'h0) begin fails++; $display("FAIL rst_ram_wrdata: got %h, required 0", bus.ram_wrdata); end
        tests++; if (bus.ram_be !== 4'h0) begin fails++; $display("FAIL rst_ram_be: got %h, required 0", bus.ram_be); end
        tests++; if (bus.cpu_readdata !== 32'h0) begin fails++; $display("FAIL rst_cpu_readdata: got %h, required 0", bus.cpu_readdata); end
        tests++; if (bus.cpu_waitrequest !== 1'b1) begin fails++; $display("FAIL rst_waitrequest: got %b, required 1", bus.cpu_waitrequest); end
        tests++; if (mon_dreg !== 32'h0) begin fails++; $display("FAIL rst_mon_dreg: got %h, required 0", mon_dreg); end
        tests++; if (mon_ready !== 1'b1) begin fails++; $display("FAIL rst_mon_ready: got %b, required 1", mon_ready); end
        tests++; if (mon_error !== 1'b0) begin fails++; $display("FAIL rst_mon_error: got %b, required 0", mon_error); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_read();
        logic [31:0] e;
        bit          ok;
        exp_rd.push_back(32'hDEADBEEF);
        strobe_set(K_A, jdo_a(8'h10, 1'b1));
        @(posedge clk); #1 strobe_set(K_NONE, '0);
        @(negedge clk);
        tests++; if (bus.ram_addr !== 8'h10 || bus.ram_wr !== 1'b0) begin fails++; $display("FAIL load_read_addr: got addr=%h wr=%b, required 10/0", bus.ram_addr, bus.ram_wr); end
        tests++; if (mon_ready !== 1'b0) begin fails++; $display("FAIL load_read_busy: got ready=%b, required 0", mon_ready); end
        repeat (2) @(posedge clk);
        #1;
        tests++; if (mon_ready !== 1'b1) begin fails++; $display("FAIL load_read_ready_n3: got %b, required 1", mon_ready); end
        e = exp_rd.pop_front();
        tests++; if (mon_dreg !== e) begin fails++; $display("FAIL load_read_data: got %h, required %h", mon_dreg, e); end
        // Pointer auto-incremented to 0x11.
        exp_rd.push_back(32'hC0DE0011);
        strobe_set(K_NA, '0);
        @(posedge clk); #1 strobe_set(K_NONE, '0);
        @(negedge clk);
        tests++; if (bus.ram_addr !== 8'h11) begin fails++; $display("FAIL jptr_incr: got addr=%h, required 11", bus.ram_addr); end
        @(posedge clk); #1;
        wait_ready(ok);
        tests++; if (!ok) begin fails++; $display("FAIL jptr_read_timeout: ready=%b, required 1", mon_ready); end
        e = exp_rd.pop_front();
        tests++; if (mon_dreg !== e) begin fails++; $display("FAIL jptr_read_data: got %h, required %h", mon_dreg, e); end
    endtask

    task automatic test_wrap_write();
        bit ok;
        exp_wr.push_back('{addr: 8'hFF, data: 32'h1, be: 4'hF});
        exp_wr.push_back('{addr: 8'h00, data: 32'h2, be: 4'hF});
        strobe_set(K_A, jdo_a(8'hFF, 1'b0));
        @(posedge clk); #1 strobe_set(K_B, jdo_b(32'h1));
        @(posedge clk); #1 strobe_set(K_B, jdo_b(32'h2));
        @(posedge clk); #1 strobe_set(K_NONE, '0);
        wait_ready(ok);
        repeat (2) @(posedge clk);
        #1;
        tests++; if (!ok) begin fails++; $display("FAIL wrap_ready_timeout: ready=%b, required 1", mon_ready); end
        tests++; if (exp_wr.size() != 0) begin fails++; $display("FAIL wrap_writes_pending: got %0d left, required 0", exp_wr.size()); end
        tests++; if (mem[255] !== 32'h1 || mem[0] !== 32'h2) begin fails++; $display("FAIL wrap_mem: got FF=%h 00=%h, required 1/2", mem[255], mem[0]); end
    endtask

    task automatic test_overflow();
        logic [31:0] e;
        bit          ok;
        strobe_set(K_A, jdo_a(8'h40, 1'b0));
        @(posedge clk); #1 strobe_set(K_NONE, '0);
        bus.cpu_address = 8'h05;
        bus.cpu_read    = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            exp_wr.push_back('{addr: 8'(8'h40 + i), data: 32'hA1 + 32'(i), be: 4'hF});
        for (int i = 0; i < 4; i++) begin
            strobe_set(K_B, jdo_b(32'hA1 + 32'(i)));
            @(posedge clk); #1;
        end
        strobe_set(K_NONE, '0);
        repeat (8) @(posedge clk);
        cpu_release(ok);
        tests++; if (!ok) begin fails++; $display("FAIL ovf_cpu_stream: no completed CPU read seen, required one"); end
        repeat (4) @(posedge clk);
        #1;
        tests++; if (exp_wr.size() != 0) begin fails++; $display("FAIL ovf_writes_pending: got %0d left, required 0", exp_wr.size()); end
        tests++; if (mon_error !== 1'b1) begin fails++; $display("FAIL ovf_error_set: got %b, required 1", mon_error); end
        // Dropped command must not have advanced the pointer or touched RAM.
        exp_rd.push_back(32'hC0DE0043);
        strobe_set(K_NA, '0);
        @(posedge clk); #1 strobe_set(K_NONE, '0);
        wait_ready(ok);
        tests++; if (!ok) begin fails++; $display("FAIL ovf_read_timeout: ready=%b, required 1", mon_ready); end
        e = exp_rd.pop_front();
        tests++; if (mon_dreg !== e) begin fails++; $display("FAIL ovf_jptr_read: got %h, required %h", mon_dreg, e); end
        strobe_set(K_A, jdo_a(8'h00, 1'b0));
        @(posedge clk); #1 strobe_set(K_NONE, '0);
        tests++; if (mon_error !== 1'b0) begin fails++; $display("FAIL ovf_error_clear: got %b, required 0", mon_error); end
    endtask

    task automatic test_round_robin();
        logic [31:0] e;
        bit          ok;
        apply_reset();
        exp_rd.push_back(32'hC0DE0030);
        exp_wr.push_back('{addr: 8'h20, data: 32'h12345678, be: 4'h3});
        strobe_set(K_A, jdo_a(8'h30, 1'b1));
        @(posedge clk); #1 strobe_set(K_NONE, '0);
        bus.cpu_address    = 8'h20;
        bus.cpu_writedata  = 32'h12345678;
        bus.cpu_byteenable = 4'h3;
        bus.cpu_write      = 1'b1;
        @(negedge clk);
        tests++; if (bus.ram_addr !== 8'h30 || bus.cpu_waitrequest !== 1'b1) begin fails++; $display("FAIL rr_first_jtag: got addr=%h wait=%b, required 30/1", bus.ram_addr, bus.cpu_waitrequest); end
        @(negedge clk);
        tests++; if (bus.cpu_waitrequest !== 1'b1) begin fails++; $display("FAIL rr_rd_jtag_wait: got %b, required 1", bus.cpu_waitrequest); end
        @(negedge clk);
        tests++; if (bus.cpu_waitrequest !== 1'b0 || bus.ram_wr !== 1'b1) begin fails++; $display("FAIL rr_cpu_write: got wait=%b wr=%b, required 0/1", bus.cpu_waitrequest, bus.ram_wr); end
        @(posedge clk); #1 bus.cpu_write = 1'b0;
        wait_ready(ok);
        tests++; if (!ok) begin fails++; $display("FAIL rr_read_timeout: ready=%b, required 1", mon_ready); end
        e = exp_rd.pop_front();
        tests++; if (mon_dreg !== e) begin fails++; $display("FAIL rr_read_data: got %h, required %h", mon_dreg, e); end
        // JTAG wins the next tie, CPU the one after that.
        exp_wr.push_back('{addr: 8'h31, data: 32'hB1, be: 4'hF});
        strobe_set(K_B, jdo_b(32'hB1));
        @(posedge clk); #1;
        exp_wr.push_back('{addr: 8'h21, data: 32'hCAFE0021, be: 4'hF});
        exp_wr.push_back('{addr: 8'h32, data: 32'hB2, be: 4'hF});
        strobe_set(K_B, jdo_b(32'hB2));
        bus.cpu_address    = 8'h21;
        bus.cpu_writedata  = 32'hCAFE0021;
        bus.cpu_byteenable = 4'hF;
        bus.cpu_write      = 1'b1;
        @(posedge clk); #1 strobe_set(K_NONE, '0);
        @(negedge clk);
        tests++; if (bus.cpu_waitrequest !== 1'b0 || bus.ram_addr !== 8'h21) begin fails++; $display("FAIL rr_alternate: got wait=%b addr=%h, required 0/21", bus.cpu_waitrequest, bus.ram_addr); end
        @(posedge clk); #1 bus.cpu_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (exp_wr.size() != 0) begin fails++; $display("FAIL rr_writes_pending: got %0d left, required 0", exp_wr.size()); end
    endtask

    task automatic test_cpu_read_contention();
        apply_reset();
        exp_wr.push_back('{addr: 8'h00, data: 32'hD1, be: 4'hF});
        strobe_set(K_B, jdo_b(32'hD1));
        @(posedge clk); #1;
        exp_wr.push_back('{addr: 8'h01, data: 32'hD2, be: 4'hF});
        strobe_set(K_B, jdo_b(32'hD2));
        bus.cpu_address = 8'h05;
        bus.cpu_read    = 1'b1;
        @(negedge clk);
        tests++; if (bus.ram_wr !== 1'b1 || bus.ram_addr !== 8'h00 || bus.cpu_waitrequest !== 1'b1) begin fails++; $display("FAIL crd_grant_j1: got wr=%b addr=%h wait=%b, required 1/00/1", bus.ram_wr, bus.ram_addr, bus.cpu_waitrequest); end
        @(posedge clk); #1 strobe_set(K_NONE, '0);
        @(negedge clk);
        tests++; if (bus.ram_wr !== 1'b0 || bus.ram_addr !== 8'h05 || bus.cpu_waitrequest !== 1'b1) begin fails++; $display("FAIL crd_grant_c: got wr=%b addr=%h wait=%b, required 0/05/1", bus.ram_wr, bus.ram_addr, bus.cpu_waitrequest); end
        @(negedge clk);
        tests++; if (bus.cpu_waitrequest !== 1'b0 || bus.cpu_readdata !== 32'hC0DE0005) begin fails++; $display("FAIL crd_rd_cpu: got wait=%b data=%h, required 0/c0de0005", bus.cpu_waitrequest, bus.cpu_readdata); end
        @(posedge clk); #1 bus.cpu_read = 1'b0;
        @(negedge clk);
        tests++; if (bus.cpu_waitrequest !== 1'b1 || bus.ram_wr !== 1'b1 || bus.ram_addr !== 8'h01) begin fails++; $display("FAIL crd_grant_j2: got wait=%b wr=%b addr=%h, required 1/1/01", bus.cpu_waitrequest, bus.ram_wr, bus.ram_addr); end
        repeat (2) @(posedge clk);
        #1;
        tests++; if (exp_wr.size() != 0) begin fails++; $display("FAIL crd_writes_pending: got %0d left, required 0", exp_wr.size()); end
    endtask

    task automatic test_reset_during_rd_jtag();
        apply_reset();
        strobe_set(K_A, jdo_a(8'h10, 1'b1));
        @(posedge clk); #1 strobe_set(K_NA, '0);
        @(posedge clk); #1 strobe_set(K_NONE, '0);
        reset_n = 1'b0;
        #1;
        tests++; if (mon_dreg !== 32'h0 || mon_ready !== 1'b1 || mon_error !== 1'b0) begin fails++; $display("FAIL rrd_mon: got dreg=%h ready=%b err=%b, required 0/1/0", mon_dreg, mon_ready, mon_error); end
        tests++; if (bus.cpu_waitrequest !== 1'b1 || bus.ram_wr !== 1'b0 || bus.ram_addr !== 8'h00 || bus.cpu_readdata !== 32'h0) begin fails++; $display("FAIL rrd_bus: got wait=%b wr=%b addr=%h rdata=%h, required 1/0/00/0", bus.cpu_waitrequest, bus.ram_wr, bus.ram_addr, bus.cpu_readdata); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (mon_dreg !== 32'h0 || mon_ready !== 1'b1) begin fails++; $display("FAIL rrd_after_release: got dreg=%h ready=%b, required 0/1", mon_dreg, mon_ready); end
        tests++; if (bus.ram_wr !== 1'b0 || bus.ram_addr !== 8'h00) begin fails++; $display("FAIL rrd_fifo_empty: got wr=%b addr=%h, required 0/00", bus.ram_wr, bus.ram_addr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_read();
        test_wrap_write();
        test_overflow();
        test_round_robin();
        test_cpu_read_contention();
        test_reset_during_rd_jtag();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
